// File: rtl/gfx_rom_server_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gfx_rom_server_pkg
// Purpose  : Shared video constants and graphics ROM fetch state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package gfx_rom_server_pkg;

    localparam int C_GFX_TIMEOUT = 15;
    localparam int C_GFX_AW      = 12;
    localparam int C_GFX_PLANE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CHAR_WAIT = 2'd1,
        ST_SPR_WAIT  = 2'd2
    } gfx_fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/gfx_port_track.sv
`default_nettype none
// ============================================================================
// Module   : gfx_port_track
// Purpose  : Per-port last-served address, valid bit, pending compare and
//            plane data hold registers.
// Revision : 1.0 - initial release
// ============================================================================
module gfx_port_track
    import gfx_rom_server_pkg::*;
#(
    parameter int AW = C_GFX_AW
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [AW-1:0]            rom_addr,
    input  logic                     load,
    input  logic [AW-1:0]            load_addr,
    input  logic [15:0]              load_data,
    output logic                     pending,
    output logic [C_GFX_PLANE_W-1:0] data1,
    output logic [C_GFX_PLANE_W-1:0] data2
);

    logic [AW-1:0]            r_last_addr;
    logic                     r_valid;
    logic [C_GFX_PLANE_W-1:0] r_data1;
    logic [C_GFX_PLANE_W-1:0] r_data2;

    // Data is filed under the address that was fetched, so a move during the
    // fetch still shows up as a mismatch afterwards.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_last_addr <= '0;
            r_valid     <= 1'b0;
            r_data1     <= '0;
            r_data2     <= '0;
        end else if (load) begin
            r_last_addr <= load_addr;
            r_valid     <= 1'b1;
            r_data1     <= load_data[7:0];
            r_data2     <= load_data[15:8];
        end
    end

    assign pending = !r_valid || (rom_addr != r_last_addr);
    assign data1   = r_data1;
    assign data2   = r_data2;

endmodule
`default_nettype wire

// File: rtl/gfx_rom_server.sv
`default_nettype none
// ============================================================================
// Module   : gfx_rom_server
// Purpose  : Arbitrates char and sprite row fetches onto one shared graphics
//            memory port with ack timeout and retry.
// Revision : 1.0 - initial release
// ============================================================================
module gfx_rom_server
    import gfx_rom_server_pkg::*;
#(
    parameter int TIMEOUT = C_GFX_TIMEOUT,
    parameter int AW      = C_GFX_AW
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [AW-1:0] char_rom_addr,
    input  logic [AW-1:0] spr_rom_addr,
    output logic [7:0]    char_data1,
    output logic [7:0]    char_data2,
    output logic [7:0]    spr_data1,
    output logic [7:0]    spr_data2,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    input  logic          mem_ack,
    input  logic [15:0]   mem_data,
    output logic          char_busy,
    output logic          spr_busy,
    output logic          timeout_err
);

    localparam int            CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

    gfx_fetch_state_t r_state;
    gfx_fetch_state_t w_next_state;
    logic [AW-1:0]    r_mem_addr;
    logic             r_mem_req;
    logic [CW-1:0]    r_wait_cnt;
    logic             r_timeout_err;

    logic             w_char_pending;
    logic             w_spr_pending;
    logic             w_char_load;
    logic             w_spr_load;
    logic             w_start;
    logic [AW-1:0]    w_start_addr;
    logic             w_end;
    logic             w_timeout;

    gfx_port_track #(.AW(AW)) u_char_track (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .rom_addr  (char_rom_addr),
        .load      (w_char_load),
        .load_addr (r_mem_addr),
        .load_data (mem_data),
        .pending   (w_char_pending),
        .data1     (char_data1),
        .data2     (char_data2)
    );

    gfx_port_track #(.AW(AW)) u_spr_track (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .rom_addr  (spr_rom_addr),
        .load      (w_spr_load),
        .load_addr (r_mem_addr),
        .load_data (mem_data),
        .pending   (w_spr_pending),
        .data1     (spr_data1),
        .data2     (spr_data2)
    );

    always_comb begin
        w_next_state = r_state;
        w_char_load  = 1'b0;
        w_spr_load   = 1'b0;
        w_start      = 1'b0;
        w_start_addr = r_mem_addr;
        w_end        = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                // Char has fixed priority; an ack arriving here is dropped.
                if (w_char_pending) begin
                    w_start      = 1'b1;
                    w_start_addr = char_rom_addr;
                    w_next_state = ST_CHAR_WAIT;
                end else if (w_spr_pending) begin
                    w_start      = 1'b1;
                    w_start_addr = spr_rom_addr;
                    w_next_state = ST_SPR_WAIT;
                end
            end
            ST_CHAR_WAIT, ST_SPR_WAIT: begin
                if (mem_ack) begin
                    w_char_load  = (r_state == ST_CHAR_WAIT);
                    w_spr_load   = (r_state == ST_SPR_WAIT);
                    w_end        = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_wait_cnt == C_CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_end        = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_mem_addr    <= '0;
            r_mem_req     <= 1'b0;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_mem_addr <= w_start_addr;
                r_mem_req  <= 1'b1;
                r_wait_cnt <= '0;
            end else begin
                if (w_end) begin
                    r_mem_req <= 1'b0;
                end
                if (r_state != ST_IDLE) begin
                    r_wait_cnt <= r_wait_cnt + CW'(1);
                end
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign mem_addr    = r_mem_addr;
    assign mem_req     = r_mem_req;
    assign timeout_err = r_timeout_err;
    assign char_busy   = w_char_pending || (r_state == ST_CHAR_WAIT);
    assign spr_busy    = w_spr_pending  || (r_state == ST_SPR_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_gfx_rom_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_gfx_rom_server
// Purpose  : Self-checking bench for gfx_rom_server with a fetch scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gfx_rom_server;

    localparam int TIMEOUT = 15;
    localparam int AW      = 12;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic [AW-1:0] char_rom_addr;
    logic [AW-1:0] spr_rom_addr;
    logic [7:0]    char_data1, char_data2, spr_data1, spr_data2;
    logic [AW-1:0] mem_addr;
    logic          mem_req;
    logic          mem_ack;
    logic [15:0]   mem_data;
    logic          char_busy, spr_busy, timeout_err;

    int            n_checks = 0;
    int            n_fails  = 0;
    logic [AW-1:0] exp_addr_q[$];
    bit            ack_en    = 1'b1;
    bit            mem_const = 1'b1;
    int            stray_req  = 0;
    int            stray_done = 0;

    gfx_rom_server #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .char_rom_addr (char_rom_addr),
        .spr_rom_addr  (spr_rom_addr),
        .char_data1    (char_data1),
        .char_data2    (char_data2),
        .spr_data1     (spr_data1),
        .spr_data2     (spr_data2),
        .mem_addr      (mem_addr),
        .mem_req       (mem_req),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .char_busy     (char_busy),
        .spr_busy      (spr_busy),
        .timeout_err   (timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] lo_of(input logic [AW-1:0] a);
        return a[7:0] ^ {4'h0, a[11:8]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] hi_of(input logic [AW-1:0] a);
        return a[11:4] ^ 8'hA5;
    endfunction

    // Memory model: acks in the second cycle of a request.
    initial begin
        int cnt;
        cnt      = 0;
        mem_ack  = 1'b0;
        mem_data = 16'h0000;
        forever begin
            @(posedge clk_sys); #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (stray_req != stray_done) begin
                mem_ack  = 1'b1;
                mem_data = 16'hFFFF;
                stray_done++;
            end else if (mem_req && ack_en) begin
                cnt++;
                if (cnt >= 2) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_const ? 16'h1234 : {hi_of(mem_addr), lo_of(mem_addr)};
                    cnt      = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Scoreboard: every new request must match the next expected address.
    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(posedge clk_sys); #1;
            if (mem_req && !prev_req) begin
                check_val("req_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) begin
                    check_val("req_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                end
            end
            prev_req = mem_req;
        end
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((char_busy || spr_busy || mem_req) && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        check_val({tag, "_idle_reached"}, 32'(n < 200), 32'd1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        check_val({tag, "_req_seen"}, 32'(n < 50), 32'd1);
    endtask

    initial begin
        int n;
        reset_n       = 1'b0;
        char_rom_addr = 12'h005;
        spr_rom_addr  = 12'h006;
        repeat (3) @(negedge clk_sys);
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_val("rst_char_data1", 32'(char_data1), 32'd0);
        check_val("rst_spr_data2", 32'(spr_data2), 32'd0);
        check_val("rst_timeout_err", 32'(timeout_err), 32'd0);

        // Boot: char fetched first, then sprite, constant 0x1234 memory.
        exp_addr_q.push_back(12'h005);
        exp_addr_q.push_back(12'h006);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check_val("boot_req", 32'(mem_req), 32'd1);
        check_val("boot_addr", 32'(mem_addr), 32'h005);
        check_val("boot_spr_busy", 32'(spr_busy), 32'd1);
        wait_idle("boot");
        check_val("boot_char_data1", 32'(char_data1), 32'h34);
        check_val("boot_char_data2", 32'(char_data2), 32'h12);
        check_val("boot_spr_data1", 32'(spr_data1), 32'h34);
        check_val("boot_spr_data2", 32'(spr_data2), 32'h12);

        // Both ports move together: char wins, each busy drops on its own ack.
        mem_const = 1'b0;
        exp_addr_q.push_back(12'h100);
        exp_addr_q.push_back(12'h200);
        char_rom_addr = 12'h100;
        spr_rom_addr  = 12'h200;
        n = 0;
        @(negedge clk_sys);
        while (char_busy && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        check_val("dual_char_done", 32'(n < 50), 32'd1);
        check_val("dual_spr_still_busy", 32'(spr_busy), 32'd1);
        check_val("dual_char_data1", 32'(char_data1), 32'(lo_of(12'h100)));
        check_val("dual_char_data2", 32'(char_data2), 32'(hi_of(12'h100)));
        wait_idle("dual");
        check_val("dual_spr_data1", 32'(spr_data1), 32'(lo_of(12'h200)));
        check_val("dual_spr_data2", 32'(spr_data2), 32'(hi_of(12'h200)));

        // Address moves during its own fetch: old data stored, then re-fetch.
        exp_addr_q.push_back(12'h010);
        exp_addr_q.push_back(12'h011);
        char_rom_addr = 12'h010;
        @(negedge clk_sys);
        wait_req("move");
        char_rom_addr = 12'h011;
        n = 0;
        while (mem_req && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        check_val("move_old_data", 32'(char_data1), 32'(lo_of(12'h010)));
        check_val("move_busy_again", 32'(char_busy), 32'd1);
        wait_idle("move");
        check_val("move_new_data1", 32'(char_data1), 32'(lo_of(12'h011)));
        check_val("move_new_data2", 32'(char_data2), 32'(hi_of(12'h011)));

        // No ack: request held exactly TIMEOUT cycles, then retried.
        ack_en = 1'b0;
        exp_addr_q.push_back(12'h020);
        exp_addr_q.push_back(12'h020);
        char_rom_addr = 12'h020;
        @(negedge clk_sys);
        wait_req("tmo");
        n = 0;
        while (mem_req && n < 100) begin
            n++;
            @(negedge clk_sys);
        end
        check_val("tmo_req_cycles", 32'(n), 32'(TIMEOUT));
        check_val("tmo_err_set", 32'(timeout_err), 32'd1);
        check_val("tmo_data_held", 32'(char_data1), 32'(lo_of(12'h011)));
        wait_req("tmo_retry");
        ack_en = 1'b1;
        wait_idle("tmo");
        check_val("tmo_retry_data1", 32'(char_data1), 32'(lo_of(12'h020)));
        check_val("tmo_err_sticky", 32'(timeout_err), 32'd1);

        // Reset mid-fetch with a stray ack while in reset.
        ack_en = 1'b0;
        exp_addr_q.push_back(12'h030);
        char_rom_addr = 12'h030;
        @(negedge clk_sys);
        wait_req("rstmid");
        reset_n = 1'b0;
        stray_req++;
        repeat (3) @(negedge clk_sys);
        check_val("rstmid_req", 32'(mem_req), 32'd0);
        check_val("rstmid_char_data1", 32'(char_data1), 32'd0);
        check_val("rstmid_spr_data1", 32'(spr_data1), 32'd0);
        check_val("rstmid_err_clear", 32'(timeout_err), 32'd0);
        exp_addr_q.push_back(12'h030);
        exp_addr_q.push_back(12'h200);
        ack_en  = 1'b1;
        reset_n = 1'b1;
        @(negedge clk_sys);
        check_val("rstmid_restart_addr", 32'(mem_addr), 32'h030);
        wait_idle("rstmid");
        check_val("rstmid_char_data2", 32'(char_data2), 32'(hi_of(12'h030)));
        check_val("rstmid_spr_data1", 32'(spr_data1), 32'(lo_of(12'h200)));

        // Quiet period: no requests, outputs hold; an idle ack is ignored.
        n = 0;
        repeat (100) begin
            @(negedge clk_sys);
            if (mem_req) n++;
        end
        check_val("quiet_no_req", 32'(n), 32'd0);
        stray_req++;
        repeat (3) @(negedge clk_sys);
        check_val("quiet_char_data1", 32'(char_data1), 32'(lo_of(12'h030)));
        check_val("quiet_spr_data2", 32'(spr_data2), 32'(hi_of(12'h200)));
        check_val("quiet_not_busy", 32'(char_busy || spr_busy), 32'd0);
        check_val("scoreboard_drained", 32'(exp_addr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
